// File: rtl/fft_pkg.sv
// Shared definitions for the 64-point radix-2 FFT stage sequencer.
// Holds the widths, the controller state encoding, the per-stage
// twiddle mask table and the 5-bit bit-reverse helper.
package fft_pkg;

    localparam int unsigned N_LOG2    = 6;
    localparam int unsigned N_PTS     = 1 << N_LOG2;
    localparam int unsigned TW_W      = 5;
    localparam int unsigned STG_W     = 3;
    localparam int unsigned CNT_W     = N_LOG2 + 1;
    localparam int unsigned DRAIN_TMO = 255;
    localparam int unsigned TMO_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_FEED,
        ST_DRAIN,
        ST_NEXT,
        ST_DONE
    } fft_ctrl_state_t;

    // Stage s keeps the top s bits of the bit-reversed feed index.
    localparam logic [TW_W-1:0] TW_MASK [N_LOG2] = '{
        5'h00, 5'h10, 5'h18, 5'h1C, 5'h1E, 5'h1F
    };

    function automatic logic [TW_W-1:0] bitrev5(input logic [TW_W-1:0] v);
        return {v[0], v[1], v[2], v[3], v[4]};
    endfunction

endpackage

// File: rtl/fft_stage_ctrl_if.sv
// Bundle of the sequencer's host handshake, sample-buffer and FFT_unit signals.
// master: the sequencer (drives everything except start and unit_is_out).
// slave : the surrounding host / buffer / unit side.
interface fft_stage_ctrl_if;
    import fft_pkg::*;

    logic              start;
    logic              busy;
    logic              done;
    logic              err;
    logic [STG_W-1:0]  stage;
    logic              rd_bank;
    logic [N_LOG2-1:0] rd_addr;
    logic [TW_W-1:0]   tw_idx;
    logic              unit_nrst;
    logic              unit_is_out;
    logic              wr_en;
    logic              wr_bank;
    logic [N_LOG2-1:0] wr_addr;

    modport master (
        input  start, unit_is_out,
        output busy, done, err, stage, rd_bank, rd_addr, tw_idx,
               unit_nrst, wr_en, wr_bank, wr_addr
    );

    modport slave (
        output start, unit_is_out,
        input  busy, done, err, stage, rd_bank, rd_addr, tw_idx,
               unit_nrst, wr_en, wr_bank, wr_addr
    );

endinterface

// File: rtl/fft_tw_addr_gen.sv
// Twiddle index generator: registers bitrev5(feed_cnt) masked by the stage mask.
// Ports: clk, rst (async, active-high); feed_cnt / stage are the values the
// controller will hold next cycle, so tw_idx lines up with rd_addr; tw_idx out.
module fft_tw_addr_gen
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [TW_W-1:0]  feed_cnt,
    input  logic [STG_W-1:0] stage,
    output logic [TW_W-1:0]  tw_idx
);

    logic [TW_W-1:0] mask_c;

    // Stage mask lookup; out-of-range stages give index 0.
    always_comb begin
        mask_c = '0;
        if (stage < STG_W'(N_LOG2)) begin
            mask_c = TW_MASK[stage];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tw_idx <= '0;
        end else begin
            tw_idx <= bitrev5(feed_cnt) & mask_c;
        end
    end

endmodule

// File: rtl/fft_stage_ctrl.sv
// Six-stage sequencer for the 64-point radix-2 FFT_unit over a ping-pong buffer.
// Ports: clk, rst (async, active-high); bus (master) carries the host
// start/busy/done/err handshake, buffer read/write addressing, the twiddle
// index and the FFT_unit reset / output-valid pair.
module fft_stage_ctrl
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    fft_stage_ctrl_if.master bus
);

    fft_ctrl_state_t   state, state_nxt;
    logic [STG_W-1:0]  stage_q, stage_nxt;
    logic [N_LOG2-1:0] feed_cnt, feed_nxt;
    logic [CNT_W-1:0]  wr_cnt, wr_cnt_nxt;
    logic [TMO_W-1:0]  tmo_cnt, tmo_nxt;
    logic              busy_q, done_q, err_q, nrst_q;
    logic              active_c, wr_en_c, wr_last_c, tmo_hit_c;

    assign active_c  = (state == ST_FEED) || (state == ST_DRAIN);
    assign wr_en_c   = bus.unit_is_out && (wr_cnt < CNT_W'(N_PTS)) && active_c;
    // Write phase is complete once the 64th capture happens (or already has).
    assign wr_last_c = (wr_cnt == CNT_W'(N_PTS)) ||
                       (wr_en_c && (wr_cnt == CNT_W'(N_PTS - 1)));
    // Timeout counter freezes at the first unit_is_out, which then stays high.
    assign tmo_hit_c = active_c && !bus.unit_is_out &&
                       (tmo_cnt == TMO_W'(DRAIN_TMO - 1));

    // Next-state and counter update.
    always_comb begin
        state_nxt  = state;
        stage_nxt  = stage_q;
        feed_nxt   = feed_cnt;
        wr_cnt_nxt = wr_cnt;
        tmo_nxt    = tmo_cnt;

        if (wr_en_c) begin
            wr_cnt_nxt = wr_cnt + CNT_W'(1);
        end
        if (active_c && !bus.unit_is_out && (tmo_cnt != TMO_W'(DRAIN_TMO))) begin
            tmo_nxt = tmo_cnt + TMO_W'(1);
        end

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt = ST_FLUSH;
                    stage_nxt = '0;
                end
            end
            ST_FLUSH: state_nxt = ST_FEED;
            ST_FEED: begin
                if (tmo_hit_c) begin
                    state_nxt = ST_IDLE;
                end else if (feed_cnt == N_LOG2'(N_PTS - 1)) begin
                    state_nxt = ST_DRAIN;
                end else begin
                    feed_nxt = feed_cnt + N_LOG2'(1);
                end
            end
            ST_DRAIN: begin
                if (tmo_hit_c) begin
                    state_nxt = ST_IDLE;
                end else if (wr_last_c) begin
                    state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (stage_q == STG_W'(N_LOG2 - 1)) begin
                    state_nxt = ST_DONE;
                end else begin
                    stage_nxt = stage_q + STG_W'(1);
                    state_nxt = ST_FLUSH;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase

        // All per-stage counters restart on entry to FLUSH.
        if (state_nxt == ST_FLUSH) begin
            feed_nxt   = '0;
            wr_cnt_nxt = '0;
            tmo_nxt    = '0;
        end
    end

    // State, counters and registered outputs (decoded from the next state).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            stage_q  <= '0;
            feed_cnt <= '0;
            wr_cnt   <= '0;
            tmo_cnt  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            nrst_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            stage_q  <= stage_nxt;
            feed_cnt <= feed_nxt;
            wr_cnt   <= wr_cnt_nxt;
            tmo_cnt  <= tmo_nxt;
            busy_q   <= state_nxt inside {ST_FLUSH, ST_FEED, ST_DRAIN, ST_NEXT};
            done_q   <= (state_nxt == ST_DONE);
            err_q    <= tmo_hit_c;
            nrst_q   <= state_nxt inside {ST_FEED, ST_DRAIN};
        end
    end

    fft_tw_addr_gen u_tw (
        .clk      (clk),
        .rst      (rst),
        .feed_cnt (feed_nxt[TW_W-1:0]),
        .stage    (stage_nxt),
        .tw_idx   (bus.tw_idx)
    );

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.stage     = stage_q;
    assign bus.rd_bank   = stage_q[0];
    assign bus.wr_bank   = ~stage_q[0];
    assign bus.rd_addr   = feed_cnt;
    assign bus.wr_addr   = wr_cnt[N_LOG2-1:0];
    assign bus.wr_en     = wr_en_c;
    assign bus.unit_nrst = nrst_q;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Bench for fft_stage_ctrl: ping-pong buffer plus a fixed-latency (3) FFT_unit
// stand-in whose output is unit_f(sample, twiddle), checked against a golden
// six-stage reference computed here.
module tb_fft_stage_ctrl;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fft_stage_ctrl_if bus ();

    fft_stage_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- buffer + unit model ----------------
    logic [15:0] mem [2][64];
    logic [15:0] res [64];
    logic [4:0]  tw_log [6][64];
    int          seg_wr [6];
    int          seg_wbank [6];
    int          seg_rbank [6];
    int          in_cnt, out_cnt, seg, total_wr, done_cnt, err_cnt;
    logic        prev_nrst, is_out_q;
    logic        mon_clr = 1'b1;
    logic        dead = 1'b0;

    function automatic logic [15:0] unit_f(input logic [15:0] x, input logic [4:0] tw);
        return x * 16'd5 + 16'(tw) * 16'd7 + 16'd3;
    endfunction

    function automatic logic [15:0] init_val(input int i);
        return 16'(i * 37 + 11);
    endfunction

    function automatic logic [4:0] exp_tw(input int s, input int i);
        logic [4:0] lo;
        logic [4:0] rev;
        int         m;
        lo  = 5'(i);
        rev = {lo[0], lo[1], lo[2], lo[3], lo[4]};
        m   = (s == 0) ? 0 : ((32'h1F << (5 - s)) & 32'h1F);
        return rev & 5'(m);
    endfunction

    always @(posedge clk) begin
        if (mon_clr) begin
            in_cnt = 0; out_cnt = 0; seg = 0; total_wr = 0;
            done_cnt = 0; err_cnt = 0; is_out_q = 1'b0; prev_nrst = 1'b0;
            for (int s = 0; s < 6; s++) begin
                seg_wr[s] = 0; seg_wbank[s] = -1; seg_rbank[s] = -1;
                for (int i = 0; i < 64; i++) tw_log[s][i] = 5'd0;
            end
            for (int i = 0; i < 64; i++) begin
                mem[0][i] = init_val(i);
                mem[1][i] = 16'd0;
                res[i]    = 16'd0;
            end
            bus.unit_is_out <= 1'b0;
        end else begin
            if (bus.unit_nrst && !prev_nrst) seg++;
            prev_nrst = bus.unit_nrst;
            if (bus.done) done_cnt++;
            if (bus.err) err_cnt++;
            if (bus.wr_en) begin
                if (out_cnt < 64) mem[bus.wr_bank][bus.wr_addr] = res[out_cnt];
                total_wr++;
                if (seg >= 1 && seg <= 6) begin
                    seg_wr[seg-1]++;
                    seg_wbank[seg-1] = int'(bus.wr_bank);
                end
            end
            if (!bus.unit_nrst) begin
                in_cnt = 0; out_cnt = 0; is_out_q = 1'b0;
            end else begin
                if (is_out_q) out_cnt++;
                if (in_cnt < 64) begin
                    res[in_cnt] = unit_f(mem[bus.rd_bank][bus.rd_addr], bus.tw_idx);
                    if (seg >= 1 && seg <= 6) begin
                        tw_log[seg-1][in_cnt] = bus.tw_idx;
                        if (in_cnt == 0) seg_rbank[seg-1] = int'(bus.rd_bank);
                    end
                    in_cnt++;
                end
                if (in_cnt >= 3 && !dead) is_out_q = 1'b1;
            end
            bus.unit_is_out <= is_out_q;
        end
    end

    // ---------------- helpers ----------------
    task automatic clear_mon();
        @(posedge clk); #1 mon_clr = 1'b1;
        @(posedge clk); #1 mon_clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 bus.start = 1'b1;
        @(negedge clk); chk("busy_before_accept", int'(bus.busy), 0);
        @(posedge clk); #1 bus.start = 1'b0;
        @(negedge clk); chk("busy_after_accept", int'(bus.busy), 1);
    endtask

    task automatic wait_done(input string name, input int limit);
        int seen;
        seen = 0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1;
                break;
            end
        end
        chk({name, "_done_seen"}, seen, 1);
    endtask

    task automatic check_bank0(input string name);
        logic [15:0] b [64];
        logic [15:0] nb [64];
        int          bad;
        for (int i = 0; i < 64; i++) b[i] = init_val(i);
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < 64; i++) nb[i] = unit_f(b[i], exp_tw(s, i));
            b = nb;
        end
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[0][i] !== b[i]) bad++;
        chk({name, "_bank0_golden_mismatches"}, bad, 0);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_busy"},      int'(bus.busy), 0);
        chk({name, "_done"},      int'(bus.done), 0);
        chk({name, "_err"},       int'(bus.err), 0);
        chk({name, "_unit_nrst"}, int'(bus.unit_nrst), 0);
        chk({name, "_stage"},     int'(bus.stage), 0);
        chk({name, "_rd_addr"},   int'(bus.rd_addr), 0);
        chk({name, "_wr_addr"},   int'(bus.wr_addr), 0);
        chk({name, "_tw_idx"},    int'(bus.tw_idx), 0);
        chk({name, "_wr_en"},     int'(bus.wr_en), 0);
        chk({name, "_wr_bank"},   int'(bus.wr_bank), 1);
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        int stg;
        int feed;
        int tw;
    } tw_vec_t;

    typedef struct {
        int stg;
        int wbank;
        int rbank;
        int writes;
    } stage_vec_t;

    tw_vec_t    tvec [12];
    stage_vec_t svec [6];

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int found;
        int n;
        int bad;

        tvec[0]  = '{0, 0, 0};   tvec[1]  = '{0, 1, 0};   tvec[2]  = '{0, 63, 0};
        tvec[3]  = '{1, 1, 16};  tvec[4]  = '{1, 2, 0};   tvec[5]  = '{2, 3, 24};
        tvec[6]  = '{3, 5, 20};  tvec[7]  = '{4, 6, 12};  tvec[8]  = '{5, 1, 16};
        tvec[9]  = '{5, 3, 24};  tvec[10] = '{5, 31, 31}; tvec[11] = '{5, 33, 16};
        svec[0] = '{0, 1, 0, 64}; svec[1] = '{1, 0, 1, 64}; svec[2] = '{2, 1, 0, 64};
        svec[3] = '{3, 0, 1, 64}; svec[4] = '{4, 1, 0, 64}; svec[5] = '{5, 0, 1, 64};

        bus.start = 1'b0;

        // Asynchronous reset, checked before any clock edge.
        #1 rst = 1'b1;
        #1 check_reset_outputs("reset");
        @(negedge clk); @(negedge clk); rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_busy", int'(bus.busy), 0);
        chk("idle_unit_nrst", int'(bus.unit_nrst), 0);

        // Full transform.
        clear_mon();
        pulse_start();
        wait_done("run1", 2000);
        chk("run1_busy_at_done", int'(bus.busy), 0);
        @(negedge clk);
        chk("run1_done_one_cycle", int'(bus.done), 0);
        chk("run1_total_writes", total_wr, 384);
        chk("run1_done_count", done_cnt, 1);
        chk("run1_err_count", err_cnt, 0);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("run1_s%0d_writes", svec[k].stg), seg_wr[svec[k].stg], svec[k].writes);
            chk($sformatf("run1_s%0d_wr_bank", svec[k].stg), seg_wbank[svec[k].stg], svec[k].wbank);
            chk($sformatf("run1_s%0d_rd_bank", svec[k].stg), seg_rbank[svec[k].stg], svec[k].rbank);
        end
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("tw_s%0d_f%0d", tvec[k].stg, tvec[k].feed),
                int'(tw_log[tvec[k].stg][tvec[k].feed]), tvec[k].tw);
        end
        bad = 0;
        for (int i = 0; i < 64; i++) if (tw_log[0][i] != 5'd0) bad++;
        chk("tw_stage0_nonzero_count", bad, 0);
        check_bank0("run1");

        // start held high through a run: one transform, next begins after IDLE.
        clear_mon();
        @(posedge clk); #1 bus.start = 1'b1;
        wait_done("held", 2000);
        @(negedge clk);
        chk("held_idle_busy", int'(bus.busy), 0);
        @(negedge clk);
        chk("held_restart_busy", int'(bus.busy), 1);
        chk("held_done_count", done_cnt, 1);
        @(posedge clk); #1 bus.start = 1'b0;
        wait_done("held_second", 2000);
        @(negedge clk);
        chk("held_done_count_final", done_cnt, 2);
        chk("held_err_count", err_cnt, 0);

        // Drain timeout: the unit never raises unit_is_out.
        clear_mon();
        dead = 1'b1;
        pulse_start();
        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.unit_nrst) begin
                found = 1;
                break;
            end
        end
        chk("tmo_feed_entry_seen", found, 1);
        n = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (bus.err) begin
                n = k;
                break;
            end
        end
        chk("tmo_err_cycle", n, 255);
        chk("tmo_busy", int'(bus.busy), 0);
        chk("tmo_unit_nrst", int'(bus.unit_nrst), 0);
        @(negedge clk);
        chk("tmo_err_one_cycle", int'(bus.err), 0);
        chk("tmo_writes", total_wr, 0);
        chk("tmo_done_count", done_cnt, 0);
        chk("tmo_err_count", err_cnt, 1);
        dead = 1'b0;

        // Reset during stage 3 DRAIN, then a clean transform.
        clear_mon();
        pulse_start();
        found = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (bus.stage == 3'd3 && bus.rd_addr == 6'd63 && bus.unit_nrst) begin
                found = 1;
                break;
            end
        end
        chk("midrst_stage3_reached", found, 1);
        @(negedge clk);
        rst = 1'b1;
        #1 check_reset_outputs("midrst");
        @(negedge clk); rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst_done_count", done_cnt, 0);
        chk("midrst_err_count", err_cnt, 0);
        chk("midrst_busy_idle", int'(bus.busy), 0);
        clear_mon();
        pulse_start();
        wait_done("rerun", 2000);
        @(negedge clk);
        chk("rerun_total_writes", total_wr, 384);
        chk("rerun_done_count", done_cnt, 1);
        check_bank0("rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
